// File: rtl/sign_cmp_pkg.sv
// Shared definitions for the signed min/max controller: comparator result codes and FSM states.
package sign_cmp_pkg;

    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StCmpMax = 3'd2,
        StCmpMin = 3'd3,
        StFin    = 3'd4
    } state_e;

endpackage

// File: rtl/sign_cmp.sv
// Combinational two's-complement comparator producing a 2-bit result code for A versus B.
module sign_cmp
    import sign_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       c
);

    always_comb begin
        c = CMP_EQ;
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            // Differing signs: the non-negative operand is the larger one.
            c = a[WIDTH-1] ? CMP_LT : CMP_GT;
        end else if (a > b) begin
            c = CMP_GT;
        end else if (a < b) begin
            c = CMP_LT;
        end
    end

endmodule

// File: rtl/sign_minmax_ctrl.sv
// Frame min/max tracker: accepts FRAME_LEN signed samples and reports extremes with earliest indices,
// sharing one comparator between the max and min checks.
module sign_minmax_ctrl
    import sign_cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] min_idx
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;

    logic [WIDTH-1:0] cmp_b;
    logic [1:0]       cmp_c;

    // The single comparator sees the running min only while in the min-check state.
    assign cmp_b = (state_q == StCmpMin) ? min_q : max_q;

    sign_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a(samp_q),
        .b(cmp_b),
        .c(cmp_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        samp_d    = samp_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    cnt_d     = '0;
                    max_d     = '0;
                    min_d     = '0;
                    max_idx_d = '0;
                    min_idx_d = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    samp_d = in_data;
                    if (cnt_q == '0) begin
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        if (FRAME_LEN == 1) begin
                            state_d = StFin;
                        end else begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = StCmpMax;
                    end
                end
            end
            StCmpMax: begin
                if (cmp_c == CMP_GT) begin
                    max_d     = samp_q;
                    max_idx_d = cnt_q;
                end
                state_d = StCmpMin;
            end
            StCmpMin: begin
                if (cmp_c == CMP_LT) begin
                    min_d     = samp_q;
                    min_idx_d = cnt_q;
                end
                if (cnt_q == LastIdx) begin
                    state_d = StFin;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = StLoad;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            samp_q    <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            samp_q    <= samp_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign max_out  = max_q;
    assign min_out  = min_q;
    assign max_idx  = max_idx_q;
    assign min_idx  = min_idx_q;

endmodule

// File: tb/tb_sign_minmax_ctrl.sv
// Randomised self-checking bench for sign_minmax_ctrl against a plain-arithmetic frame model.
module tb_sign_minmax_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [3:0] max_out;
    logic [3:0] min_out;
    logic [2:0] max_idx;
    logic [2:0] min_idx;

    logic [3:0] ca, cb;
    logic [1:0] cc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] smp [8];
    logic [3:0] exp_max, exp_min;
    logic [2:0] exp_max_i, exp_min_i;

    sign_minmax_ctrl #(
        .WIDTH(4),
        .FRAME_LEN(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .busy(busy),
        .done(done),
        .max_out(max_out),
        .min_out(min_out),
        .max_idx(max_idx),
        .min_idx(min_idx)
    );

    sign_cmp #(
        .WIDTH(4)
    ) u_cmp_ref (
        .a(ca),
        .b(cb),
        .c(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_frame(input logic [31:0] packed_s);
        for (int i = 0; i < 8; i++) smp[i] = packed_s[31-4*i -: 4];
    endtask

    // Frame extremes by signed arithmetic; strict compares keep the earliest index on ties.
    task automatic model();
        int mx, mn, v, mxi, mni;
        mx = $signed(smp[0]);
        mn = mx;
        mxi = 0;
        mni = 0;
        for (int i = 1; i < 8; i++) begin
            v = $signed(smp[i]);
            if (v > mx) begin mx = v; mxi = i; end
            if (v < mn) begin mn = v; mni = i; end
        end
        exp_max   = mx[3:0];
        exp_min   = mn[3:0];
        exp_max_i = mxi[2:0];
        exp_min_i = mni[2:0];
    endtask

    task automatic run_frame(input int gap, input bit poke_start, input bit chk_lat);
        int cyc, idx, wait_n, last_x, done_cyc, start_cyc, ready_block;
        model();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'($urandom);
        chk("ready_in_idle", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", busy, 1);
        chk("results_cleared", {max_out, min_out, max_idx, min_idx}, 0);
        idx = 0; wait_n = gap; last_x = 0; done_cyc = 0; start_cyc = -1; ready_block = 0;
        while (cyc < 400 && done_cyc == 0) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (ready_block > 0) begin
                    chk("ready_low_in_cmp", in_ready, 0);
                    ready_block--;
                end
                start = (cyc == start_cyc);
                if (idx < 8 && wait_n == 0) begin
                    in_valid = 1'b1;
                    in_data  = smp[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data  = 4'($urandom);
                    if (wait_n > 0) wait_n--;
                end
                if (in_valid && in_ready) begin
                    idx++;
                    wait_n = gap;
                    last_x = cyc;
                    if (idx >= 2) ready_block = 2;
                    if (poke_start && idx == 2) start_cyc = cyc + 1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (done_cyc == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("samples_taken", idx, 8);
            chk("done_latency", done_cyc, last_x + 3);
            if (chk_lat) chk("done_cycle_23", done_cyc, 23);
            chk("max_out", max_out, exp_max);
            chk("max_idx", max_idx, exp_max_i);
            chk("min_out", min_out, exp_min);
            chk("min_idx", min_idx, exp_min_i);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            chk("ready_after_done", in_ready, 0);
            chk("max_held", max_out, exp_max);
            chk("min_held", min_out, exp_min);
        end
    endtask

    task automatic reset_mid_frame();
        int idx, guard;
        set_frame(32'h3E708581);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 3 && guard < 50) begin
            in_valid = 1'b1;
            in_data  = smp[idx];
            if (in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("pre_reset_max_nonzero", (max_out != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {max_out, min_out, max_idx, min_idx}, 0);
        chk("async_rst_flags", {busy, done, in_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, 0);
        end
    endtask

    initial begin
        int sa, sb;
        logic [1:0] ec;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ca       = '0;
        cb       = '0;
        #1;
        chk("reset_outputs", {max_out, min_out, max_idx, min_idx}, 0);
        chk("reset_flags", {busy, done, in_ready}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ca = a[3:0];
                cb = b[3:0];
                #1;
                sa = $signed(ca);
                sb = $signed(cb);
                ec = (sa == sb) ? 2'b01 : (sa > sb) ? 2'b10 : 2'b11;
                chk("sign_cmp", cc, ec);
            end
        end

        set_frame(32'h3E708581);
        run_frame(0, 1'b0, 1'b1);
        set_frame(32'h0F0F0F0F);
        run_frame(0, 1'b0, 1'b1);
        set_frame(32'h44444444);
        run_frame(0, 1'b0, 1'b1);
        set_frame(32'h3E708581);
        run_frame(4, 1'b0, 1'b0);
        set_frame(32'h3E708581);
        run_frame(0, 1'b1, 1'b1);

        reset_mid_frame();
        set_frame(32'h3E708581);
        run_frame(1, 1'b0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            set_frame($urandom);
            run_frame(int'($urandom_range(0, 2)), f[0], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sign_minmax_ctrl.md
Name: sign_minmax_ctrl

Overview:
- Sequencing controller that streams a frame of FRAME_LEN signed two's-complement samples and reports the frame maximum and minimum, with the index of each.
- Owns one shared signed comparator and time-multiplexes it between the running-max and running-min checks. Each sample takes two compare cycles.
- Sits between a sample producer (valid/ready) and a result consumer (DONE pulse plus held results).

Parameters:
- WIDTH, 4, sample width in bits (two's complement).
- FRAME_LEN, 8, samples per frame; legal range 1..256.
- IDX_W, $clog2(FRAME_LEN) (minimum 1), width of the index outputs.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  frame start request; honoured only in IDLE.
- IN_VALID  in  1  producer has a sample on IN_DATA.
- IN_DATA  in  WIDTH  signed sample.
- IN_READY  out  1  controller accepts a sample this cycle.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when results are final.
- MAX_OUT  out  WIDTH  largest sample of the frame.
- MIN_OUT  out  WIDTH  smallest sample of the frame.
- MAX_IDX  out  IDX_W  index of MAX_OUT; on ties, the earliest index wins.
- MIN_IDX  out  IDX_W  index of MIN_OUT; on ties, the earliest index wins.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - All outputs, the sample register and the counter go to 0; IN_READY=0.
  - If asserted mid-frame, the partial frame is discarded and DONE is not produced.
- States: IDLE, LOAD, CMP_MAX, CMP_MIN, FIN.
- IDLE:
  - START=1 → LOAD. Counter cnt clears to 0; MAX_OUT, MIN_OUT, MAX_IDX and MIN_IDX clear to 0.
  - START is ignored in every other state.
- LOAD:
  - IN_READY=1 (Moore output, decoded from state only).
  - A transfer occurs when IN_VALID=1 in LOAD; the sample is captured into SAMP.
  - If cnt==0: MAX_OUT=MIN_OUT=IN_DATA and MAX_IDX=MIN_IDX=0. Then, if FRAME_LEN==1 → FIN, else cnt+1 and stay in LOAD.
  - If cnt>0 → CMP_MAX.
  - IN_VALID=0 holds LOAD indefinitely; there is no timeout.
- CMP_MAX:
  - Comparator A=SAMP, B=MAX_OUT.
  - Result "A greater" → MAX_OUT=SAMP, MAX_IDX=cnt. Equal or less → no change.
  - Next state: CMP_MIN.
- CMP_MIN:
  - Comparator A=SAMP, B=MIN_OUT.
  - Result "A less" → MIN_OUT=SAMP, MIN_IDX=cnt.
  - If cnt==FRAME_LEN-1 → FIN, else cnt+1 → LOAD.
- FIN:
  - DONE=1 for exactly this cycle, then → IDLE.
  - Results hold until the next accepted START.
- Comparator semantics:
  - Signed two's complement: sign bits differ → the operand with sign 0 is greater; sign bits equal → unsigned compare of the full words.
  - 2-bit result code: 01 equal, 10 A>B, 11 A<B; 00 unused.
- Timing:
  - Sustained rate: 3 cycles per sample (LOAD, CMP_MAX, CMP_MIN) with IN_VALID held high.
  - Latency: transfer of the last sample at edge k → DONE high in the cycle after edge k+2.
  - Full frame of 8 with continuous valid: START edge → DONE 1+1+7*3 = 23 cycles later.
- Boundaries:
  - cnt wraps never; the frame ends at FRAME_LEN-1.
  - START and IN_VALID together in IDLE: only START acts; the sample is not consumed (IN_READY=0).
  - IN_DATA changes while IN_READY=0 have no effect.

Decomposition:
- Shared package sign_cmp_pkg:
  - CMP_EQ=2'b01, CMP_GT=2'b10, CMP_LT=2'b11.
  - State encoding constants for IDLE/LOAD/CMP_MAX/CMP_MIN/FIN.
- One sub-module: sign_cmp (parameter WIDTH; inputs A, B; output C[1:0]). Purely combinational, instantiated once; its operand B is muxed by state between MAX_OUT and MIN_OUT.

Test Plan:
- Nominal frame: START, then samples 3,-2,7,0,-8,5,-8,1 with IN_VALID held high → DONE at cycle 23 after START; MAX_OUT=7 (4'b0111), MAX_IDX=2, MIN_OUT=-8 (4'b1000), MIN_IDX=4 (earliest tie); BUSY low after DONE.
- Sign boundary: frame 0,-1,0,-1,0,-1,0,-1 → MAX_OUT=0 idx 0; MIN_OUT=4'b1111 idx 1. Also check sign_cmp(0000,1111)=10 and sign_cmp(1010,1001)=10.
- All equal: eight samples of 4'b0100 → MAX_OUT=MIN_OUT=4 and both indices 0; sign_cmp returns 01 on every compare.
- Backpressure: nominal frame with IN_VALID low for 4 cycles before each sample → same results as the nominal frame; IN_READY high only in LOAD; no sample lost or duplicated.
- START while busy and reset mid-frame:
  - Pulse START during CMP_MAX → ignored, results unchanged.
  - Drop RST_N after sample 3 → all outputs 0 immediately (asynchronously), no DONE.
  - A new frame afterwards completes correctly.
